// File: rtl/msg_checker.sv
// msg_checker: scans the decrypted message in the result RAM and checks each
// byte against the plaintext alphabet (space, 'a'..'z').
//
// Ports:
//   clk, reset_n        clock / async active-low reset
//   start               level request, held until the result is consumed
//   addr_ram, q_ram     read port to the result RAM (RD_LAT edges addr->data)
//   done, pass          result valid / every byte legal
//   bad_index           index of the first illegal byte (0 on pass)
//   char_count          legal bytes scanned before stopping
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs at reset values, waiting for start
// SCAN  | issuing one read address per edge, checking returning bytes
// DRAIN | all addresses issued, checking bytes still in flight
// DONE  | result frozen on the outputs until start drops
module msg_checker #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5,
   parameter int RD_LAT  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] addr_ram,
   input  logic [7:0]        q_ram,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] bad_index,
   output logic [ADDR_W:0]   char_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [ADDR_W:0]   LAST_ISS  = (ADDR_W+1)'(MSG_LEN-1);
   localparam logic [ADDR_W:0]   MSG_LEN_W = (ADDR_W+1)'(MSG_LEN);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN-1);

   state_e                         state_q, state_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic [ADDR_W:0]                iss_q, iss_d;
   logic [RD_LAT-1:0]              vld_q, vld_d;
   logic [RD_LAT-1:0][ADDR_W-1:0]  idx_q, idx_d;
   logic [ADDR_W:0]                cnt_q, cnt_d;
   logic                           res_pass_q, res_pass_d;
   logic [ADDR_W-1:0]              res_bad_q, res_bad_d;
   logic                           done_q, done_d;
   logic                           pass_q, pass_d;
   logic [ADDR_W-1:0]              bad_q, bad_d;

   logic              chk_v;
   logic [ADDR_W-1:0] chk_idx;
   logic              chk_ok;
   logic              chk_bad;
   logic              chk_last;
   logic              active;
   logic              issue;

   // Oldest slot of the in-flight pipe lines up with the data on q_ram.
   assign chk_v    = vld_q[RD_LAT-1];
   assign chk_idx  = idx_q[RD_LAT-1];
   assign chk_ok   = (q_ram == 8'h20) || ((q_ram >= 8'h61) && (q_ram <= 8'h7A));
   assign chk_bad  = chk_v && !chk_ok;
   assign chk_last = chk_v && chk_ok && (chk_idx == LAST_IDX);
   assign active   = ((state_q == SCAN) || (state_q == DRAIN)) && start;
   assign issue    = ((state_q == IDLE) && start) ||
                     ((state_q == SCAN) && start && !chk_bad);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         iss_q      <= '0;
         vld_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         res_pass_q <= 1'b0;
         res_bad_q  <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         bad_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         iss_q      <= iss_d;
         vld_q      <= vld_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         res_pass_q <= res_pass_d;
         res_bad_q  <= res_bad_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         bad_q      <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = (LAST_ISS == '0) ? DRAIN : SCAN;
         end
         SCAN: begin
            if (!start)                      state_d = IDLE;
            else if (chk_bad || chk_last)    state_d = DONE;
            else if (iss_q == LAST_ISS)      state_d = DRAIN;
         end
         DRAIN: begin
            if (!start)                      state_d = IDLE;
            else if (chk_bad || chk_last)    state_d = DONE;
         end
         DONE: begin
            if (!start)                      state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d     = addr_q;
      iss_d      = iss_q;
      cnt_d      = cnt_q;
      res_pass_d = res_pass_q;
      res_bad_d  = res_bad_q;
      vld_d      = '0;
      idx_d      = idx_q;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      bad_d      = '0;

      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         idx_d[i] = idx_q[i-1];
      end

      if (issue) begin
         if (state_q == IDLE) begin
            addr_d = '0;
            iss_d  = (ADDR_W+1)'(1);
         end else begin
            addr_d = iss_q[ADDR_W-1:0];
            iss_d  = iss_q + 1'b1;
         end
         vld_d[0] = 1'b1;
         idx_d[0] = addr_d;
      end

      if (active && chk_v) begin
         if (chk_ok) begin
            if (cnt_q < MSG_LEN_W) cnt_d = cnt_q + 1'b1;
            if (chk_last) begin
               res_pass_d = 1'b1;
               res_bad_d  = '0;
            end
         end else begin
            // First failure wins; later bytes already in flight are dropped.
            res_pass_d = 1'b0;
            res_bad_d  = chk_idx;
            vld_d      = '0;
         end
      end

      // Dropping start abandons any scan and clears everything.
      if (!start) begin
         addr_d = '0;
         iss_d  = '0;
         cnt_d  = '0;
         vld_d  = '0;
      end

      // Result outputs trail the DONE entry by one edge so they all move together.
      if ((state_q == DONE) && start) begin
         done_d = 1'b1;
         pass_d = res_pass_q;
         bad_d  = res_bad_q;
         vld_d  = '0;
      end
   end

   assign addr_ram   = addr_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign bad_index  = bad_q;
   assign char_count = cnt_q;

endmodule

// File: tb/tb_msg_checker.sv
module tb_msg_checker;

   localparam int MSG_LEN = 32;
   localparam int ADDR_W  = 5;
   localparam int RD_LAT  = 2;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic [ADDR_W-1:0] addr_ram;
   logic [7:0]        q_ram;
   logic              done;
   logic              pass;
   logic [ADDR_W-1:0] bad_index;
   logic [ADDR_W:0]   char_count;

   logic [7:0] mem [MSG_LEN];
   string      alpha = "abcdefghijklmnopqrstuvwxyz ";
   string      fox   = "the quick brown fox jumps over t";
   int         tests = 0;
   int         fails = 0;

   msg_checker #(
      .MSG_LEN (MSG_LEN),
      .ADDR_W  (ADDR_W),
      .RD_LAT  (RD_LAT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .addr_ram   (addr_ram),
      .q_ram      (q_ram),
      .done       (done),
      .pass       (pass),
      .bad_index  (bad_index),
      .char_count (char_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: address registered by the DUT at Ek, read here at E(k+1),
   // so the DUT sees the byte when it samples at E(k+2).
   always @(posedge clk) q_ram <= mem[addr_ram];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [7:0] c);
      for (int j = 0; j < alpha.len(); j++)
         if (c == alpha[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int first_bad();
      for (int i = 0; i < MSG_LEN; i++)
         if (!is_legal(mem[i])) return i;
      return -1;
   endfunction

   task automatic load_fox();
      for (int i = 0; i < MSG_LEN; i++) mem[i] = fox[i];
   endtask

   task automatic load_random_legal();
      for (int i = 0; i < MSG_LEN; i++) mem[i] = alpha[$urandom_range(0, 26)];
   endtask

   // Runs one full check. If raise=1, start goes high at the next negedge;
   // otherwise start is already high and the next posedge is E0.
   task automatic run_scan(input bit raise, input string tag);
      int          b, exp_edge, got_edge, exp_addr, last_issue;
      int          exp_pass, exp_bad, exp_cnt;
      bit          addr_ok;
      logic [12:0] exp_res;
      b          = first_bad();
      exp_pass   = (b < 0) ? 1 : 0;
      exp_bad    = (b < 0) ? 0 : b;
      exp_cnt    = (b < 0) ? MSG_LEN : b;
      exp_edge   = (b < 0) ? (MSG_LEN - 1 + RD_LAT + 1) : (b + RD_LAT + 1);
      last_issue = (b < 0) ? (MSG_LEN - 1) : (b + RD_LAT - 1);
      if (last_issue > MSG_LEN - 1) last_issue = MSG_LEN - 1;
      if (raise) begin
         @(negedge clk);
         start = 1'b1;
      end
      got_edge = -1;
      addr_ok  = 1'b1;
      for (int n = 0; n < 60 && got_edge < 0; n++) begin
         @(posedge clk);
         #1;
         exp_addr = (n < last_issue) ? n : last_issue;
         if (addr_ram !== ADDR_W'(exp_addr)) addr_ok = 1'b0;
         if (done === 1'b1) got_edge = n;
      end
      check({tag, "_done_edge"}, got_edge, exp_edge);
      check({tag, "_pass"}, pass, exp_pass);
      check({tag, "_bad_index"}, bad_index, exp_bad);
      check({tag, "_char_count"}, char_count, exp_cnt);
      check({tag, "_addr_trace"}, addr_ok, 1);
      repeat (2) @(posedge clk);
      #1;
      exp_res = {1'b1, 1'(exp_pass), ADDR_W'(exp_bad), 6'(exp_cnt)};
      check({tag, "_frozen"}, {done, pass, bad_index, char_count}, exp_res);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_cleared"}, {done, pass, bad_index, char_count, addr_ram}, 0);
   endtask

   logic [7:0] bnd [7];
   bit         abort_done_seen;

   initial begin
      bnd = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h21, 8'h60, 8'h7B};
      reset_n = 1'b0;
      start   = 1'b0;
      load_fox();
      repeat (2) @(negedge clk);
      check("rst_addr", addr_ram, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_bad_index", bad_index, 0);
      check("rst_char_count", char_count, 0);
      reset_n = 1'b1;
      @(negedge clk);

      load_fox();
      run_scan(1'b1, "all_legal");

      load_fox();
      mem[0] = 8'h41;
      run_scan(1'b1, "first_bad");

      load_fox();
      mem[17] = 8'h7B;
      mem[25] = 8'h00;
      run_scan(1'b1, "mid_bad");

      load_fox();
      mem[31] = 8'h60;
      run_scan(1'b1, "last_bad");

      for (int i = 0; i < 7; i++) begin
         load_fox();
         mem[5] = bnd[i];
         run_scan(1'b1, $sformatf("boundary_%02h", bnd[i]));
      end

      for (int r = 0; r < 6; r++) begin
         int nbad;
         load_random_legal();
         nbad = $urandom_range(0, 2);
         for (int k = 0; k < nbad; k++)
            mem[$urandom_range(0, MSG_LEN - 1)] = 8'($urandom_range(0, 255));
         run_scan(1'b1, $sformatf("random_%0d", r));
      end

      // Abort at E10, restart so the new scan's E0 is the old E12.
      load_random_legal();
      abort_done_seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) abort_done_seen = 1'b1;
      end
      check("abort_addr_before_drop", addr_ram, 9);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) abort_done_seen = 1'b1;
      check("abort_addr_idle", addr_ram, 0);
      @(posedge clk);
      #1;
      if (done === 1'b1) abort_done_seen = 1'b1;
      check("abort_no_done", abort_done_seen, 0);
      run_scan(1'b1, "restart");

      // Asynchronous reset between E12 and E13.
      load_fox();
      @(negedge clk);
      start = 1'b1;
      for (int n = 0; n < 13; n++) begin
         @(posedge clk);
         #1;
      end
      check("pre_reset_addr", addr_ram, 12);
      check("pre_reset_count", char_count, 11);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_addr", addr_ram, 0);
      check("async_rst_count", char_count, 0);
      check("async_rst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_scan(1'b0, "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
